// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM encoding, initial hash values, round constants and the
// bitwise round functions used by the compression stage.
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // H0 sits in the most significant word so the vector maps directly onto the digest.
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] xx;
        xx = {x, x};
        return xx[n +: 32];
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] t);
        logic [31:0] k;
        case (t)
            6'd0:  k = 32'h428a2f98;
            6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;
            6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;
            6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;
            6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;
            6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;
            6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;
            6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;
            6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;
            6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;
            6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;
            6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;
            6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;
            6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;
            6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;
            6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;
            6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;
            6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;
            6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;
            6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;
            6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;
            6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;
            6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;
            6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;
            6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;
            6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;
            6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;
            6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;
            6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;
            6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;
            6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;
            6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: working variables a..h packed with a in [255:224].
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] vars_in,
    input  logic [31:0]  k_in,
    input  logic [31:0]  w_in,
    output logic [255:0] vars_out
);

    logic [31:0] a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s;
    logic [31:0] t1_s, t2_s;

    // One round: compute T1/T2 and shift the working variables down by one word.
    always_comb begin
        {a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s} = vars_in;
        t1_s = h_s + big_sigma1(e_s) + ch(e_s, f_s, g_s) + k_in + w_in;
        t2_s = big_sigma0(a_s) + maj(a_s, b_s, c_s);
        vars_out = {t1_s + t2_s, a_s, b_s, c_s, d_s + t1_s, e_s, f_s, g_s};
    end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression stage: one round per accepted W word, chaining H across blocks.
// Build macro SHA224_EN adds mode224_in (SHA-224 IV and zeroed final digest word).
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_in,
    input  logic                    first_block_in,
`ifdef SHA224_EN
    input  logic                    mode224_in,
`endif
    input  logic [DATA_WIDTH-1:0]   w_in,
    input  logic                    w_valid_in,
    output logic                    w_ready_out,
    output logic [6:0]              round_out,
    output logic                    busy_out,
    output logic [8*DATA_WIDTH-1:0] digest_out,
    output logic                    digest_valid_out
);

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    state_e       state_q, state_d;
    logic [6:0]   round_q, round_d;
    logic [255:0] work_q, work_d;
    logic [255:0] hash_q, hash_d;
    logic [255:0] digest_q, digest_d;
    logic         w_ready_q, w_ready_d;
    logic         busy_q, busy_d;
    logic         digest_valid_q, digest_valid_d;
    logic [255:0] round_next_s;
    logic [255:0] sum_s;
    logic [255:0] iv_s;
    logic [31:0]  k_s;
`ifdef SHA224_EN
    logic         mode_q, mode_d;
`endif

    assign k_s = k_const(round_q[5:0]);

    sha256_round u_round (
        .vars_in  (work_q),
        .k_in     (k_s),
        .w_in     (w_in),
        .vars_out (round_next_s)
    );

    // Initial hash selection for a first block.
    always_comb begin
`ifdef SHA224_EN
        if (mode224_in) begin
            iv_s = IV224;
        end else begin
            iv_s = IV256;
        end
`else
        iv_s = IV256;
`endif
    end

    // Word-wise modulo-2^32 feed-forward of the working variables into H.
    always_comb begin
        sum_s = 256'd0;
        for (int i = 0; i < 8; i++) begin
            sum_s[i*32 +: 32] = hash_q[i*32 +: 32] + work_q[i*32 +: 32];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        work_d   = work_q;
        hash_d   = hash_q;
        digest_d = digest_q;
`ifdef SHA224_EN
        mode_d   = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_LOAD;
                    if (first_block_in) begin
                        hash_d = iv_s;
`ifdef SHA224_EN
                        mode_d = mode224_in;
`endif
                    end else begin
                        hash_d = hash_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                work_d  = hash_q;
                round_d = 7'd0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // A cycle without w_valid_in is a full stall: nothing moves.
                if (w_valid_in) begin
                    work_d = round_next_s;
                    if (round_q == LAST_ROUND) begin
                        state_d = S_UPDATE;
                    end else begin
                        round_d = round_q + 7'd1;
                    end
                end else begin
                    work_d = work_q;
                end
            end
            S_UPDATE: begin
                hash_d  = sum_s;
                state_d = S_DONE;
`ifdef SHA224_EN
                if (mode_q) begin
                    digest_d = {sum_s[255:32], 32'h00000000};
                end else begin
                    digest_d = sum_s;
                end
`else
                digest_d = sum_s;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        w_ready_d      = (state_d == S_ROUND);
        busy_d         = (state_d != S_IDLE);
        digest_valid_d = (state_d == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            round_q        <= 7'd0;
            work_q         <= 256'd0;
            hash_q         <= IV256;
            digest_q       <= IV256;
            w_ready_q      <= 1'b0;
            busy_q         <= 1'b0;
            digest_valid_q <= 1'b0;
`ifdef SHA224_EN
            mode_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            work_q         <= work_d;
            hash_q         <= hash_d;
            digest_q       <= digest_d;
            w_ready_q      <= w_ready_d;
            busy_q         <= busy_d;
            digest_valid_q <= digest_valid_d;
`ifdef SHA224_EN
            mode_q         <= mode_d;
`endif
        end
    end

    assign w_ready_out      = w_ready_q;
    assign round_out        = round_q;
    assign busy_out         = busy_q;
    assign digest_out       = digest_q;
    assign digest_valid_out = digest_valid_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: pads and expands messages itself, streams W with
// random stalls and compares against a behavioural compression model and known digests.
module tb_sha256_compress;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_in = 1'b0;
    logic         first_block_in = 1'b0;
    logic [31:0]  w_in = 32'h0;
    logic         w_valid_in = 1'b0;
    logic         w_ready_out;
    logic [6:0]   round_out;
    logic         busy_out;
    logic [255:0] digest_out;
    logic         digest_valid_out;
`ifdef SHA224_EN
    logic         mode224_in = 1'b0;
`endif

    sha256_compress dut (
        .clk              (clk),
        .rst              (rst),
        .start_in         (start_in),
        .first_block_in   (first_block_in),
`ifdef SHA224_EN
        .mode224_in       (mode224_in),
`endif
        .w_in             (w_in),
        .w_valid_in       (w_valid_in),
        .w_ready_out      (w_ready_out),
        .round_out        (round_out),
        .busy_out         (busy_out),
        .digest_out       (digest_out),
        .digest_valid_out (digest_valid_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam logic [255:0] IV256_VEC   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIGEST  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic [7:0]   msg_bytes [128];
    int           msg_len;
    logic [7:0]   pad [128];
    int           n_blocks;
    logic [31:0]  cur_w [64];
    logic [31:0]  model_h [8];
    logic [255:0] held_digest;
    bit           use224 = 1'b0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model_digest();
        return {model_h[0], model_h[1], model_h[2], model_h[3],
                model_h[4], model_h[5], model_h[6], model_h[7]};
    endfunction

    task automatic load_str(input string s);
        msg_len = s.len();
        for (int i = 0; i < msg_len; i++) msg_bytes[i] = s[i];
    endtask

    task automatic pad_message();
        logic [63:0] bits;
        int total;
        for (int i = 0; i < 128; i++) pad[i] = 8'h00;
        for (int i = 0; i < msg_len; i++) pad[i] = msg_bytes[i];
        pad[msg_len] = 8'h80;
        n_blocks = (msg_len + 9 + 63) / 64;
        total = n_blocks * 64;
        bits = 64'(msg_len) * 64'd8;
        for (int b = 0; b < 8; b++) pad[total - 1 - b] = bits[8*b +: 8];
    endtask

    task automatic expand(input int blk);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++)
            cur_w[t] = {pad[blk*64 + 4*t], pad[blk*64 + 4*t + 1], pad[blk*64 + 4*t + 2], pad[blk*64 + 4*t + 3]};
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(cur_w[t-15], 7) ^ rotr(cur_w[t-15], 18) ^ (cur_w[t-15] >> 3);
            s1 = rotr(cur_w[t-2], 17) ^ rotr(cur_w[t-2], 19) ^ (cur_w[t-2] >> 10);
            cur_w[t] = cur_w[t-16] + s0 + cur_w[t-7] + s1;
        end
    endtask

    task automatic model_compress();
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 8; i++) v[i] = model_h[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + cur_w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) model_h[i] = model_h[i] + v[i];
    endtask

    // Streams cur_w through the DUT; cycles counts edges from the start-sampling edge to digest_valid.
    task automatic run_block(input bit first, input int stall_pct, input int poke_at,
                             input int abort_at, output int cycles, output int nstall);
        int idx;
        bit fire, done, seen_round;
        logic [255:0] md;
        idx = 0; fire = 0; done = 0; seen_round = 0; cycles = 0; nstall = 0;
        if (first) begin
            for (int i = 0; i < 8; i++) model_h[i] = use224 ? iv224[i] : iv256[i];
        end
        @(negedge clk);
        start_in = 1'b1; first_block_in = first;
        w_valid_in = 1'($urandom); w_in = $urandom;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            cycles++;
            start_in = 1'b0; first_block_in = 1'($urandom);
            if (fire) idx++;
            fire = 0;
            if (digest_valid_out) begin
                done = 1;
            end else if (w_ready_out) begin
                if (!seen_round) begin
                    seen_round = 1;
                    n_checks++;
                    if (digest_out !== held_digest) begin
                        n_fail++;
                        $display("FAIL digest_hold: got %h expected %h", digest_out, held_digest);
                    end
                end
                n_checks++;
                if (round_out !== 7'(idx)) begin
                    n_fail++;
                    $display("FAIL round_index: round_out=%0d expected %0d", round_out, idx);
                end
                if (idx == abort_at) begin
                    rst = 1'b1; w_valid_in = 1'b0;
                    return;
                end
                if (idx == poke_at) start_in = 1'b1;
                if ($urandom_range(99) < 32'(stall_pct)) begin
                    w_valid_in = 1'b0; w_in = $urandom; nstall++;
                end else begin
                    w_valid_in = 1'b1; w_in = cur_w[idx]; fire = 1;
                end
            end else begin
                w_valid_in = 1'($urandom); w_in = $urandom;
            end
        end
        w_valid_in = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL block_timeout: no digest_valid_out after %0d cycles, expected one", cycles);
        end else begin
            model_compress();
            md = model_digest();
            held_digest = use224 ? {md[255:32], 32'h0} : md;
            @(negedge clk);
            n_checks++;
            if ({digest_valid_out, busy_out} !== 2'b00) begin
                n_fail++;
                $display("FAIL done_pulse: valid,busy=%b expected 00", {digest_valid_out, busy_out});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        held_digest = IV256_VEC;
        n_checks++;
        if ({busy_out, w_ready_out, digest_valid_out, round_out, digest_out} !== {3'b000, 7'd0, IV256_VEC}) begin
            n_fail++;
            $display("FAIL reset_state: busy,ready,valid=%b round=%0d digest=%h", {busy_out, w_ready_out, digest_valid_out}, round_out, digest_out);
        end
    endtask

    task automatic test_abc();
        int cyc, ns;
        load_str("abc"); pad_message(); expand(0);
        run_block(1'b1, 0, -1, -1, cyc, ns);
        n_checks++;
        if (cyc !== 67) begin n_fail++; $display("FAIL abc_latency: got %0d expected 67", cyc); end
        n_checks++;
        if (digest_out !== ABC_DIGEST) begin n_fail++; $display("FAIL abc_digest: got %h expected %h", digest_out, ABC_DIGEST); end
        n_checks++;
        if (digest_out !== held_digest) begin n_fail++; $display("FAIL abc_model: got %h expected %h", digest_out, held_digest); end
    endtask

    task automatic test_empty();
        int cyc, ns;
        load_str(""); pad_message(); expand(0);
        run_block(1'b1, 0, -1, -1, cyc, ns);
        n_checks++;
        if (digest_out !== EMPTY_DIGEST) begin n_fail++; $display("FAIL empty_digest: got %h expected %h", digest_out, EMPTY_DIGEST); end
    endtask

    task automatic test_two_block();
        int cyc, ns;
        load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"); pad_message();
        n_checks++;
        if (n_blocks !== 2) begin n_fail++; $display("FAIL two_block_count: got %0d expected 2", n_blocks); end
        expand(0);
        run_block(1'b1, 10, -1, -1, cyc, ns);
        n_checks++;
        if (digest_out !== held_digest) begin n_fail++; $display("FAIL two_block_mid: got %h expected %h", digest_out, held_digest); end
        expand(1);
        run_block(1'b0, 10, -1, -1, cyc, ns);
        n_checks++;
        if (digest_out !== TWO_DIGEST) begin n_fail++; $display("FAIL two_block_digest: got %h expected %h", digest_out, TWO_DIGEST); end
    endtask

    task automatic test_stalls();
        int cyc, ns;
        load_str("abc"); pad_message(); expand(0);
        run_block(1'b1, 30, -1, -1, cyc, ns);
        n_checks++;
        if (cyc !== 67 + ns) begin n_fail++; $display("FAIL stall_latency: got %0d expected %0d", cyc, 67 + ns); end
        n_checks++;
        if (digest_out !== ABC_DIGEST) begin n_fail++; $display("FAIL stall_digest: got %h expected %h", digest_out, ABC_DIGEST); end
    endtask

    task automatic test_reset_mid();
        int cyc, ns;
        load_str("abc"); pad_message(); expand(0);
        run_block(1'b1, 20, -1, 30, cyc, ns);
        @(negedge clk);
        rst = 1'b0;
        held_digest = IV256_VEC;
        n_checks++;
        if ({busy_out, w_ready_out, digest_valid_out, round_out, digest_out} !== {3'b000, 7'd0, IV256_VEC}) begin
            n_fail++;
            $display("FAIL mid_reset_state: busy,ready,valid=%b round=%0d digest=%h", {busy_out, w_ready_out, digest_valid_out}, round_out, digest_out);
        end
        run_block(1'b1, 0, 20, -1, cyc, ns);
        n_checks++;
        if (cyc !== 67) begin n_fail++; $display("FAIL restart_latency: got %0d expected 67", cyc); end
        n_checks++;
        if (digest_out !== ABC_DIGEST) begin n_fail++; $display("FAIL restart_digest: got %h expected %h", digest_out, ABC_DIGEST); end
    endtask

    task automatic test_random_msgs();
        int cyc, ns;
        for (int m = 0; m < 4; m++) begin
            msg_len = int'($urandom_range(55));
            for (int i = 0; i < msg_len; i++) msg_bytes[i] = 8'($urandom);
            pad_message(); expand(0);
            run_block(1'b1, 25, -1, -1, cyc, ns);
            n_checks++;
            if (digest_out !== held_digest) begin n_fail++; $display("FAIL random_msg%0d: got %h expected %h", m, digest_out, held_digest); end
        end
    endtask

    task automatic test_chain();
        int cyc, ns;
        for (int b = 0; b < 3; b++) begin
            for (int t = 0; t < 64; t++) cur_w[t] = $urandom;
            run_block(b == 0, 15, -1, -1, cyc, ns);
            n_checks++;
            if (digest_out !== held_digest) begin n_fail++; $display("FAIL chain_block%0d: got %h expected %h", b, digest_out, held_digest); end
        end
    endtask

`ifdef SHA224_EN
    task automatic test_sha224();
        int cyc, ns;
        logic [255:0] exp224;
        exp224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
        load_str("abc"); pad_message(); expand(0);
        use224 = 1'b1; mode224_in = 1'b1;
        run_block(1'b1, 0, -1, -1, cyc, ns);
        mode224_in = 1'b0; use224 = 1'b0;
        n_checks++;
        if (digest_out !== exp224) begin n_fail++; $display("FAIL sha224_digest: got %h expected %h", digest_out, exp224); end
        n_checks++;
        if (digest_out !== held_digest) begin n_fail++; $display("FAIL sha224_model: got %h expected %h", digest_out, held_digest); end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_stalls();
        test_reset_mid();
        test_random_msgs();
        test_chain();
`ifdef SHA224_EN
        test_sha224();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
- Compression stage directly downstream of the message-expansion stage.
- Consumes the W[0..63] word stream, one 32-bit word per accepted cycle, and runs the 64 SHA-256 rounds on working variables a..h.
- Adds the result into the chaining hash H0..H7 and presents the 256-bit digest after each 512-bit block.
- Holds chaining state across blocks of one message.

Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- ROUNDS, 64, rounds per block; fixed by the standard.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  one-cycle pulse that begins a block; honoured only in IDLE.
- first_block_in  in  1  sampled with start_in; 1 = load the IV into H, 0 = continue from the current H.
- w_in  in  DATA_WIDTH  message-schedule word W[t] from the expansion stage.
- w_valid_in  in  1  w_in is valid this cycle.
- w_ready_out  out  1  high in ROUND; a word transfers when w_valid_in and w_ready_out are both high.
- round_out  out  7  index t of the next word expected (0..63); drives the expansion stage's count.
- busy_out  out  1  high in every state except IDLE.
- digest_out  out  8*DATA_WIDTH  {H0,...,H7}, with H0 in [255:224]; updated in UPDATE, held otherwise.
- digest_valid_out  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state=IDLE; round_out=0; a..h=0; H=IV; w_ready_out=0; busy_out=0; digest_valid_out=0; digest_out=IV.
- Reset mid-block aborts the block immediately and discards all state.
- IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- FSM states:
  - IDLE: on start_in, go to LOAD. If first_block_in=1, H<=IV.
  - LOAD (1 cycle): a..h <= H, i.e. the IV when first_block_in=1, else the previous digest. round_out<=0.
  - ROUND: w_ready_out=1. Each transfer performs one round using K[round_out] and w_in, then increments round_out. A cycle without w_valid_in is a stall: no state changes. The transfer with round_out=63 moves to UPDATE.
  - UPDATE (1 cycle): Hi <= Hi + working variable i, modulo 2^32, for each word.
  - DONE (1 cycle): digest_valid_out=1, then return to IDLE.
- Round equations: T1 = h + Sigma1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = Sigma0(a) + Maj(a,b,c). All sums truncate to 32 bits.
  - Shift: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
- Latency: with no stalls, start_in to digest_valid_out is 67 cycles (LOAD 1 + ROUND 64 + UPDATE 1 + DONE 1).
- start_in outside IDLE is ignored. w_valid_in outside ROUND is ignored.
- round_out wraps from 63 to 0 only via LOAD; it never exceeds 63.
- digest_out holds its value between blocks, so continuation blocks chain from it.

Optional Feature:
- Macro: SHA224_EN.
- Defined:
  - Extra port mode224_in (in, 1), sampled with start_in when first_block_in=1.
  - If mode224_in=1, H loads the SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
  - In SHA-224 mode, digest_out[31:0] is forced to 0 while the block is in 224 mode.
- Undefined: the port is absent and the block is SHA-256 only. Area is identical except for the IV mux.

Decomposition:
- Shared package sha256_pkg holds:
  - the FSM state encoding;
  - the IV constants (and the 224 IV);
  - the K[0..63] table as a constant function;
  - the Sigma0/Sigma1/Ch/Maj functions.
- One natural sub-module: sha256_round, the combinational single round (inputs a..h, K, W; outputs next a..h). It is reusable by the verification model.

Test Plan:
- "abc": one padded block, first_block_in=1, W streamed with no stalls -> digest_valid_out at cycle 67; digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message: one block -> digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": two blocks, the second with first_block_in=0 -> final digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- "abc" with w_valid_in randomly low about 30% of cycles -> same digest as the no-stall case; round_out is unchanged on stall cycles; total latency = 67 + number of stall cycles.
- rst asserted at round 30, then "abc" restarted -> all outputs at reset values one cycle after rst; correct "abc" digest afterwards. A start_in pulse during ROUND -> no effect.
- With SHA224_EN defined, "abc" and mode224_in=1 -> digest_out[255:32] = 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7; digest_out[31:0] = 0.
